// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer behind the coin FSM: queues product/change requests
// and drives motor and coin-return actuators one service at a time.
module vend_dispense_ctrl #(
  parameter int QW        = 3,
  parameter int SW        = 4,
  parameter int STOCK     = 2,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int GAP_LEN   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          y1,
  input  logic          y2,
  input  logic          drop_sense,
  output logic          motor_en,
  output logic          coin_ret,
  output logic          busy,
  output logic          sold_out,
  output logic          fault,
  output logic          overflow,
  output logic [QW-1:0] prod_pend,
  output logic [QW-1:0] chg_pend,
  output logic [SW-1:0] stock
);

  localparam int CW   = $clog2(TIMEOUT + PULSE_LEN + GAP_LEN + 1);
  localparam int QMAX = (2 ** QW) - 1;

  typedef enum logic [2:0] {
    IDLE,
    PROD_ON,
    PROD_WAIT,
    CHG_ON,
    GAP,
    FAULT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          seen, seen_nx;
  logic          prod_dec, chg_dec, drop_ok;
  logic          p_inc, refund;
  logic [QW:0]   p_sum, c_sum;
  logic          p_sat, c_sat;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    seen_nx  = seen;
    prod_dec = 1'b0;
    chg_dec  = 1'b0;
    drop_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx  = '0;
        seen_nx = 1'b0;
        if (prod_pend != '0) begin
          prod_dec = 1'b1;
          state_nx = (stock != '0) ? PROD_ON : CHG_ON;
        end else if (chg_pend != '0) begin
          chg_dec  = 1'b1;
          state_nx = CHG_ON;
        end
      end
      PROD_ON: begin
        seen_nx = seen | drop_sense;
        if (cnt == CW'(PULSE_LEN - 1)) begin
          cnt_nx = '0;
          if (seen_nx) begin
            drop_ok  = 1'b1;
            state_nx = GAP;
          end else begin
            state_nx = PROD_WAIT;
          end
        end
      end
      PROD_WAIT: begin
        if (drop_sense) begin
          drop_ok  = 1'b1;
          cnt_nx   = '0;
          state_nx = GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt_nx   = '0;
          state_nx = FAULT;
        end
      end
      CHG_ON: begin
        if (cnt == CW'(PULSE_LEN - 1)) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_LEN - 1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      FAULT: begin
        cnt_nx = '0;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Empty stock turns a product request into a refund at capture time.
  assign refund = y1 & (stock == '0);
  assign p_inc  = y1 & (stock != '0);

  assign p_sum = {1'b0, prod_pend}
               + (QW+1)'(p_inc)
               - (QW+1)'(prod_dec);
  assign c_sum = {1'b0, chg_pend}
               + (QW+1)'(y2)
               + (QW+1)'(refund)
               - (QW+1)'(chg_dec);

  assign p_sat = p_sum > (QW+1)'(QMAX);
  assign c_sat = c_sum > (QW+1)'(QMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      seen      <= 1'b0;
      prod_pend <= '0;
      chg_pend  <= '0;
      stock     <= SW'(STOCK);
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      seen      <= seen_nx;
      prod_pend <= p_sat ? QW'(QMAX) : p_sum[QW-1:0];
      chg_pend  <= c_sat ? QW'(QMAX) : c_sum[QW-1:0];
      overflow  <= overflow | p_sat | c_sat;
      if (drop_ok && stock != '0)
        stock <= stock - SW'(1);
    end
  end

  assign motor_en = (state == PROD_ON);
  assign coin_ret = (state == CHG_ON);
  assign busy     = (state != IDLE);
  assign fault    = (state == FAULT);
  assign sold_out = (stock == '0);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed scenarios plus random request
// batches scored against a transaction-level model of the service order.
module tb_vend_dispense_ctrl;

  localparam int QW = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          y1 = 1'b0;
  logic          y2 = 1'b0;
  logic          drop_sense = 1'b0;
  logic          motor_en, coin_ret, busy;
  logic          sold_out, fault, overflow;
  logic [QW-1:0] prod_pend, chg_pend;
  logic [SW-1:0] stock;

  int checks = 0;
  int errors = 0;
  int expq[$];
  bit mon_en = 1'b1;
  bit drop_auto = 1'b0;
  int m_stock = 2;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .y1         (y1),
    .y2         (y2),
    .drop_sense (drop_sense),
    .motor_en   (motor_en),
    .coin_ret   (coin_ret),
    .busy       (busy),
    .sold_out   (sold_out),
    .fault      (fault),
    .overflow   (overflow),
    .prod_pend  (prod_pend),
    .chg_pend   (chg_pend),
    .stock      (stock)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: 0 = motor service, 1 = coin service
  logic pm = 1'b0, pc = 1'b0;
  int   plen = 0;
  int   k;
  always @(negedge clk) begin
    if (mon_en) begin
      if ((motor_en && !pm) || (coin_ret && !pc)) begin
        chk("mutex", int'(motor_en & coin_ret), 0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got motor=%0d coin=%0d expected none",
                   motor_en, coin_ret);
        end else begin
          k = expq.pop_front();
          chk("pulse_kind", coin_ret ? 1 : 0, k);
        end
        plen = 1;
      end else if (motor_en || coin_ret) begin
        plen++;
      end
      if ((!motor_en && pm) || (!coin_ret && pc))
        chk("pulse_len", plen, 4);
    end
    pm = motor_en;
    pc = coin_ret;
  end

  // Drop sensor: fires once per motor service, inside the pulse or wait window
  initial begin
    logic dpm;
    int   d;
    dpm = 1'b0;
    forever begin
      @(negedge clk);
      if (drop_auto && motor_en && !dpm) begin
        d = $urandom_range(0, 10);
        repeat (d) @(negedge clk);
        drop_sense = 1'b1;
        @(negedge clk);
        drop_sense = 1'b0;
      end
      dpm = motor_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0;
    y1 = 1'b0;
    y2 = 1'b0;
    drop_sense = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_stock = 2;
  endtask

  task automatic pulse(input logic a, input logic b);
    y1 = a;
    y2 = b;
    @(negedge clk);
    y1 = 1'b0;
    y2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    int ok;
    n = 0;
    ok = 0;
    while (n < 400 && ok < 2) begin
      @(negedge clk);
      n++;
      if (!busy && prod_pend == '0 && chg_pend == '0) ok++;
      else ok = 0;
    end
    if (ok < 2) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    chk("sb_drained", expq.size(), 0);
  endtask

  initial begin
    int n;
    int seen_c;
    @(negedge clk);
    chk("rst_motor", motor_en, 0);
    chk("rst_coin", coin_ret, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stock", stock, 2);
    chk("rst_sold", sold_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pend", prod_pend + chg_pend, 0);
    reset = 1'b1;
    @(negedge clk);

    // single product, drop in third motor cycle
    drop_auto = 1'b0;
    expq.push_back(0);
    pulse(1'b1, 1'b0);
    chk("d1_prod_pend", prod_pend, 1);
    chk("d1_motor_early", motor_en, 0);
    @(negedge clk);
    chk("d1_motor_on", motor_en, 1);
    chk("d1_prod_dec", prod_pend, 0);
    repeat (2) @(negedge clk);
    drop_sense = 1'b1;
    @(negedge clk);
    drop_sense = 1'b0;
    chk("d1_motor_4th", motor_en, 1);
    @(negedge clk);
    chk("d1_gap_motor", motor_en, 0);
    chk("d1_gap_busy", busy, 1);
    chk("d1_stock_dec", stock, 1);
    @(negedge clk);
    chk("d1_gap2_busy", busy, 1);
    @(negedge clk);
    chk("d1_idle", busy, 0);
    wait_idle();
    chk("d1_stock", stock, 1);

    // product and change on the same edge
    do_reset();
    drop_auto = 1'b1;
    expq.push_back(0);
    expq.push_back(1);
    pulse(1'b1, 1'b1);
    wait_idle();
    chk("d2_pend", prod_pend + chg_pend, 0);
    chk("d2_stock", stock, 1);

    // three products with stock of two
    do_reset();
    expq.push_back(0);
    expq.push_back(0);
    expq.push_back(1);
    y1 = 1'b1;
    repeat (3) @(negedge clk);
    y1 = 1'b0;
    wait_idle();
    chk("d3_stock", stock, 0);
    chk("d3_sold", sold_out, 1);

    // drop timeout, then saturation while faulted
    do_reset();
    drop_auto = 1'b0;
    expq.push_back(0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    n = 0;
    while (!fault && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("d4_fault_lat", n, 20);
    chk("d4_fault", fault, 1);
    chk("d4_stock", stock, 2);
    pulse(1'b0, 1'b1);
    chk("d4_chg_pend", chg_pend, 1);
    seen_c = 0;
    repeat (10) begin
      @(negedge clk);
      seen_c = seen_c | int'(coin_ret);
    end
    chk("d4_no_coin", seen_c, 0);
    y2 = 1'b1;
    repeat (9) @(negedge clk);
    y2 = 1'b0;
    chk("d4_chg_sat", chg_pend, 7);
    chk("d4_ovf", overflow, 1);
    reset = 1'b0;
    #1;
    chk("d4_rst_fault", fault, 0);
    chk("d4_rst_chg", chg_pend, 0);
    chk("d4_rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // asynchronous abort mid-service
    mon_en = 1'b0;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("d5_motor_on", motor_en, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("d5_async_motor", motor_en, 0);
    chk("d5_async_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("d5_stock", stock, 2);
    chk("d5_pend", prod_pend + chg_pend, 0);
    chk("d5_busy", busy, 0);
    expq.delete();
    m_stock = 2;
    mon_en = 1'b1;

    // random batches against the service-order model
    drop_auto = 1'b1;
    repeat (30) begin
      logic a[3];
      logic b[3];
      int nb, p, c, s, cc;
      if ($urandom_range(0, 3) == 0) do_reset();
      nb = $urandom_range(1, 3);
      p = 0;
      c = 0;
      for (int i = 0; i < 3; i++) begin
        a[i] = (i < nb) ? 1'($urandom_range(0, 1)) : 1'b0;
        b[i] = (i < nb) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!a[0] && !b[0]) b[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        p += int'(a[i]);
        c += int'(b[i]);
      end
      if (m_stock == 0) begin
        repeat (p + c) expq.push_back(1);
      end else begin
        s = m_stock;
        cc = c;
        if (!a[0]) begin
          expq.push_back(1);
          cc--;
        end
        repeat (p) begin
          if (s > 0) begin
            expq.push_back(0);
            s--;
          end else begin
            expq.push_back(1);
          end
        end
        repeat (cc) expq.push_back(1);
        m_stock = s;
      end
      for (int i = 0; i < nb; i++) begin
        y1 = a[i];
        y2 = b[i];
        @(negedge clk);
      end
      y1 = 1'b0;
      y2 = 1'b0;
      wait_idle();
      chk("rnd_stock", stock, m_stock);
      chk("rnd_sold", sold_out, (m_stock == 0) ? 1 : 0);
      chk("rnd_ovf", overflow, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
